// File: rtl/demux_dispatch_ctrl.sv
// ============================================================================
//  Module      : demux_dispatch_ctrl
//  Description : FIFO-buffered dispatcher steering tagged words to one of two
//                sinks through a shared 2-line demux, valid/ready per sink.
//                Optional per-word stall timeout: DISPATCH_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_dispatch_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_dest,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         dmx_data,
    output logic                     sel,
    output logic                     out0_valid,
    input  logic                     out0_ready,
    output logic                     out1_valid,
    input  logic                     out1_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     drop
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH:0]     r_mem [DEPTH];
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_cw-1:0]    r_count;
    logic [c_cw-1:0]    w_count_next;
    logic               r_in_ready;
    logic [WIDTH-1:0]   r_dmx_data;
    logic               r_sel;

    logic               w_push;
    logic               w_pop;
    logic               w_present;
    logic               w_sel_ready;
    logic               w_done;
    logic               w_timeout;
    logic               w_release;
    logic [WIDTH:0]     w_head;

    assign w_present   = (r_state == ST_PRESENT);
    assign w_sel_ready = r_sel ? out1_ready : out0_ready;
    assign w_done      = w_present & w_sel_ready;
    assign w_release   = w_done | w_timeout;
    assign w_push      = in_valid & r_in_ready;
    // A pop happens when idle with data, or on the same edge the current word leaves.
    assign w_pop       = (r_count != '0) & (~w_present | w_release);
    assign w_head      = r_mem[r_rd_ptr];

`ifdef DISPATCH_TIMEOUT_EN
    localparam int c_sw = $clog2(TIMEOUT + 1);

    logic [c_sw-1:0]    r_stall;

    assign w_timeout = w_present & ~w_sel_ready & (r_stall == c_sw'(TIMEOUT));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_stall <= '0;
        end else if (w_release || w_pop) begin
            r_stall <= '0;
        end else if (w_present) begin
            r_stall <= r_stall + c_sw'(1);
        end
    end
`else
    logic               w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_cw'(1);
            2'b01:   w_count_next = r_count - c_cw'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (w_release && (r_count == '0)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
            r_dmx_data <= '0;
            r_sel      <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            // Registered so the producer never sees a combinational path from sink ready.
            r_in_ready <= (w_count_next != c_cw'(DEPTH));
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_aw'(1);
                r_dmx_data <= w_head[WIDTH-1:0];
                r_sel      <= w_head[WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_dest, in_data};
        end
    end

    assign in_ready   = r_in_ready;
    assign dmx_data   = r_dmx_data;
    assign sel        = r_sel;
    assign out0_valid = w_present & ~r_sel;
    assign out1_valid = w_present &  r_sel;
    assign count      = r_count;
    assign busy       = w_present | (r_count != '0);
    assign drop       = w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_demux_dispatch_ctrl.sv
// ============================================================================
//  Module      : tb_demux_dispatch_ctrl
//  Description : Self-checking bench for demux_dispatch_ctrl with a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_dispatch_ctrl;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;
`ifdef DISPATCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_dest = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] dmx_data;
    logic       sel;
    logic       out0_valid;
    logic       out0_ready = 1'b0;
    logic       out1_valid;
    logic       out1_ready = 1'b0;
    logic [2:0] count;
    logic       busy;
    logic       drop;

    int errors = 0;
    int checks = 0;

    demux_dispatch_ctrl #(.WIDTH(8), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .clr        (clr),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dmx_data   (dmx_data),
        .sel        (sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .count      (count),
        .busy       (busy),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    // Model: queue of waiting words plus the word currently offered to a sink.
    logic [8:0] q[$];
    bit         m_present;
    logic [7:0] m_data;
    logic       m_sel;
    int         m_stall;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_present = 1'b0;
        m_data    = '0;
        m_sel     = 1'b0;
        m_stall   = 0;
    endtask

    task automatic model_step();
        int         n;
        bit         acc;
        bit         rel;
        logic [8:0] w;
        n   = q.size();
        acc = in_valid && (n != DEPTH);
        rel = m_present && ((m_sel ? out1_ready : out0_ready) || (TO_EN && m_stall == TIMEOUT));
        if (rel) begin
            m_present = 1'b0;
        end else if (m_present) begin
            m_stall++;
        end
        if (!m_present && n > 0) begin
            w = q.pop_front();
            m_present = 1'b1;
            m_data    = w[7:0];
            m_sel     = w[8];
            m_stall   = 0;
        end
        if (acc) q.push_back({in_dest, in_data});
    endtask

    always @(posedge clk or posedge clr) begin
        if (clr) model_reset();
        else     model_step();
    end

    always begin
        @(negedge clk);
        #2;
        chk("in_ready",   in_ready,   q.size() != DEPTH);
        chk("count",      count,      q.size());
        chk("busy",       busy,       m_present || q.size() != 0);
        chk("out0_valid", out0_valid, m_present && !m_sel);
        chk("out1_valid", out1_valid, m_present && m_sel);
        chk("dmx_data",   dmx_data,   m_data);
        chk("sel",        sel,        m_sel);
        chk("drop",       drop,       TO_EN && m_present && !(m_sel ? out1_ready : out0_ready)
                                      && m_stall == TIMEOUT);
    end

    task automatic wc();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic dst);
        in_data  = d;
        in_dest  = dst;
        in_valid = 1'b1;
        wc();
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) wc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        model_reset();
        wc(); wc();
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        clr = 1'b0;
        wc();

        // Reset mid-transfer with three words queued.
        out0_ready = 1'b0; out1_ready = 1'b0;
        push(8'h01, 1'b0); push(8'h02, 1'b1); push(8'h03, 1'b0); push(8'h04, 1'b1);
        idle_cycles(1);
        chk("t1_pre_count", count, 3);
        chk("t1_pre_v0", out0_valid, 1);
        clr = 1'b1;
        #1;
        chk("t1_v0", out0_valid, 0);
        chk("t1_v1", out1_valid, 0);
        chk("t1_count", count, 0);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_sel", sel, 0);
        chk("t1_busy", busy, 0);
        wc();
        clr = 1'b0;
        wc();

        // Two words, sinks always ready: back-to-back presentation.
        out0_ready = 1'b1; out1_ready = 1'b1;
        push(8'hA5, 1'b0);
        chk("t2_count1", count, 1);
        push(8'h3C, 1'b1);
        chk("t2_v0", out0_valid, 1);
        chk("t2_d0", dmx_data, 8'hA5);
        chk("t2_s0", sel, 0);
        idle_cycles(1);
        chk("t2_v1", out1_valid, 1);
        chk("t2_d1", dmx_data, 8'h3C);
        chk("t2_s1", sel, 1);
        idle_cycles(1);
        chk("t2_idle_v1", out1_valid, 0);
        chk("t2_hold", dmx_data, 8'h3C);
        chk("t2_busy", busy, 0);

        // Fill with sinks stalled, extra push refused, then drain in order.
        out0_ready = 1'b0; out1_ready = 1'b0;
        push(8'h11, 1'b0); push(8'h22, 1'b1); push(8'h33, 1'b0);
        push(8'h44, 1'b1); push(8'h55, 1'b0);
        chk("t3_full_count", count, 4);
        chk("t3_in_ready", in_ready, 0);
        push(8'h66, 1'b1);
        chk("t3_refused", count, 4);
        in_valid = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        wc();
        chk("t3_second", dmx_data, 8'h22);
        idle_cycles(6);
        chk("t3_drained", busy, 0);

        // Head-of-line: dest1 blocked while sink 0 is ready.
        out0_ready = 1'b1; out1_ready = 1'b0;
        push(8'h77, 1'b1); push(8'h88, 1'b0);
        idle_cycles(3);
        chk("t4_v0", out0_valid, 0);
        chk("t4_v1", out1_valid, 1);
        chk("t4_head", dmx_data, 8'h77);
        chk("t4_count", count, 1);
        out1_ready = 1'b1;
        idle_cycles(1);
        chk("t4_next", dmx_data, 8'h88);
        idle_cycles(3);

        // Simultaneous push and pop.
        out0_ready = 1'b0; out1_ready = 1'b0;
        push(8'hB1, 1'b0); push(8'hB2, 1'b1); push(8'hB3, 1'b0);
        chk("t5_count2", count, 2);
        out0_ready = 1'b1; out1_ready = 1'b1;
        push(8'hB4, 1'b1);
        chk("t5_pushpop", count, 2);
        out0_ready = 1'b0; out1_ready = 1'b0;
        push(8'hB5, 1'b0); push(8'hB6, 1'b1);
        chk("t5_full", count, 4);
        out0_ready = 1'b1; out1_ready = 1'b1;
        push(8'hB7, 1'b0);
        chk("t5_refused", count, 3);
        chk("t5_in_ready", in_ready, 1);
        idle_cycles(6);
        chk("t5_drained", busy, 0);

`ifdef DISPATCH_TIMEOUT_EN
        // Timeout: sink 0 never ready, word dropped after TIMEOUT stall cycles.
        out0_ready = 1'b0; out1_ready = 1'b1;
        push(8'hAA, 1'b0); push(8'hBB, 1'b1);
        in_valid = 1'b0;
        for (int k = 0; k < TIMEOUT; k++) begin
            chk("t6_no_drop", drop, 0);
            wc();
        end
        chk("t6_drop", drop, 1);
        wc();
        chk("t6_drop_pulse", drop, 0);
        chk("t6_next", dmx_data, 8'hBB);
        chk("t6_next_v1", out1_valid, 1);
        idle_cycles(2);
`endif

        wc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
